// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic-light lamp monitor: FSM states, fault codes
// and the per-direction lamp history type.
package tlc_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_PASS  = 2'd1;
  localparam logic [1:0] ST_FLASH = 2'd2;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_ONEHOT   = 3'd2;
  localparam logic [2:0] FC_SKIPYEL  = 3'd3;
  localparam logic [2:0] FC_SHORTYEL = 3'd4;

  typedef enum logic [1:0] {
    LAMP_NONE = 2'd0,
    LAMP_RED  = 2'd1,
    LAMP_YEL  = 2'd2,
    LAMP_GRN  = 2'd3
  } lamp_e;

  // Anything other than exactly one lit lamp decodes to LAMP_NONE.
  function automatic lamp_e lamp_decode(input logic red, input logic grn, input logic yel);
    lamp_e res;
    case ({red, grn, yel})
      3'b100:  res = LAMP_RED;
      3'b010:  res = LAMP_GRN;
      3'b001:  res = LAMP_YEL;
      default: res = LAMP_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tlc_dir_checker.sv
// Per-direction sequence checker: one-hot flag, last valid lamp, yellow run
// length and the skipped/short yellow strobes for the current sample.
module tlc_dir_checker
  import tlc_pkg::*;
#(
  parameter int YEL_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hist_clr_i,
  input  logic       red_i,
  input  logic       grn_i,
  input  logic       yel_i,
  output logic       onehot_o,
  output lamp_e      prev_o,
  output logic [7:0] ycnt_o,
  output logic       skip_o,
  output logic       short_o
);

  localparam logic [31:0] YEL_MIN_U = 32'(YEL_MIN);

  lamp_e      cur_s;
  lamp_e      prev_d;
  lamp_e      prev_q;
  logic [7:0] ycnt_d;
  logic [7:0] ycnt_q;

  // Decode the sample, raise strobes and compute the next history.
  always_comb begin
    cur_s    = lamp_decode(red_i, grn_i, yel_i);
    onehot_o = (cur_s != LAMP_NONE);
    skip_o   = (prev_q == LAMP_GRN) && red_i;
    short_o  = (prev_q == LAMP_YEL) && red_i && ({24'd0, ycnt_q} < YEL_MIN_U);
    if (hist_clr_i) begin
      prev_d = LAMP_NONE;
      ycnt_d = 8'd0;
    end else if (cur_s == LAMP_YEL) begin
      prev_d = cur_s;
      ycnt_d = (ycnt_q == 8'd255) ? ycnt_q : ycnt_q + 8'd1;
    end else begin
      prev_d = cur_s;
      ycnt_d = 8'd0;
    end
  end

  // History registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= LAMP_NONE;
      ycnt_q <= 8'd0;
    end else begin
      prev_q <= prev_d;
      ycnt_q <= ycnt_d;
    end
  end

  assign prev_o = prev_q;
  assign ycnt_o = ycnt_q;

endmodule

// File: rtl/tlc_lamp_monitor.sv
// Lamp monitor between a traffic light controller and the lamp drivers: all-red
// start-up, pass-through with fault checking, and latched fail-safe red flashing.
module tlc_lamp_monitor
  import tlc_pkg::*;
#(
  parameter int STARTUP    = 4,
  parameter int PERSIST    = 2,
  parameter int YEL_MIN    = 2,
  parameter int FLASH_HALF = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EW_Red,
  input  logic       EW_Green,
  input  logic       EW_Yellow,
  input  logic       NS_Red,
  input  logic       NS_Green,
  input  logic       NS_Yellow,
  input  logic       fault_clr,
  output logic       EW_Red_o,
  output logic       EW_Green_o,
  output logic       EW_Yellow_o,
  output logic       NS_Red_o,
  output logic       NS_Green_o,
  output logic       NS_Yellow_o,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [5:0]  LAMPS_RED    = 6'b100_100;
  localparam logic [15:0] STARTUP_LAST = 16'(STARTUP - 1);
  localparam logic [15:0] FLASH_LAST   = 16'(FLASH_HALF - 1);
  localparam logic [15:0] PERSIST_LAST = 16'(PERSIST - 1);

  logic [1:0]  state_d, state_q;
  logic [15:0] init_cnt_d, init_cnt_q;
  logic [15:0] flash_cnt_d, flash_cnt_q;
  logic        flash_lvl_d, flash_lvl_q;
  logic [15:0] pers_d, pers_q;
  logic        fault_d, fault_q;
  logic [2:0]  code_d, code_q;
  logic [5:0]  lamp_d, lamp_q;

  logic [5:0]  lamp_in_s;
  logic        hist_clr_s;
  logic        conflict_s, static_s, static_hit_s;
  logic [2:0]  latch_code_s;
  logic        ew_onehot_s, ew_skip_s, ew_short_s;
  logic        ns_onehot_s, ns_skip_s, ns_short_s;
  lamp_e       ew_prev_unused_s, ns_prev_unused_s;
  logic [7:0]  ew_ycnt_unused_s, ns_ycnt_unused_s;

  assign lamp_in_s  = {EW_Red, EW_Green, EW_Yellow, NS_Red, NS_Green, NS_Yellow};
  assign hist_clr_s = (state_q == ST_FLASH) && fault_clr;

  tlc_dir_checker #(.YEL_MIN(YEL_MIN)) u_ew (
    .clk(clk), .reset(reset), .hist_clr_i(hist_clr_s),
    .red_i(EW_Red), .grn_i(EW_Green), .yel_i(EW_Yellow),
    .onehot_o(ew_onehot_s), .prev_o(ew_prev_unused_s), .ycnt_o(ew_ycnt_unused_s),
    .skip_o(ew_skip_s), .short_o(ew_short_s)
  );

  tlc_dir_checker #(.YEL_MIN(YEL_MIN)) u_ns (
    .clk(clk), .reset(reset), .hist_clr_i(hist_clr_s),
    .red_i(NS_Red), .grn_i(NS_Green), .yel_i(NS_Yellow),
    .onehot_o(ns_onehot_s), .prev_o(ns_prev_unused_s), .ycnt_o(ns_ycnt_unused_s),
    .skip_o(ns_skip_s), .short_o(ns_short_s)
  );

  // Fault qualification and priority encoding.
  always_comb begin
    conflict_s   = (EW_Green | EW_Yellow) & (NS_Green | NS_Yellow);
    static_s     = conflict_s | ~ew_onehot_s | ~ns_onehot_s;
    static_hit_s = static_s && (pers_q >= PERSIST_LAST);
    if (static_hit_s && conflict_s) begin
      latch_code_s = FC_CONFLICT;
    end else if (static_hit_s) begin
      latch_code_s = FC_ONEHOT;
    end else if (ew_skip_s || ns_skip_s) begin
      latch_code_s = FC_SKIPYEL;
    end else if (ew_short_s || ns_short_s) begin
      latch_code_s = FC_SHORTYEL;
    end else begin
      latch_code_s = FC_NONE;
    end
  end

  // Monitor FSM, counters and next lamp drive.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    flash_cnt_d = flash_cnt_q;
    flash_lvl_d = flash_lvl_q;
    pers_d      = 16'd0;
    fault_d     = fault_q;
    code_d      = code_q;
    lamp_d      = LAMPS_RED;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == STARTUP_LAST) begin
          state_d    = ST_PASS;
          init_cnt_d = 16'd0;
        end else begin
          init_cnt_d = init_cnt_q + 16'd1;
        end
      end
      ST_PASS: begin
        pers_d = static_s ? pers_q + 16'd1 : 16'd0;
        if (latch_code_s != FC_NONE) begin
          state_d     = ST_FLASH;
          fault_d     = 1'b1;
          code_d      = latch_code_s;
          flash_cnt_d = 16'd0;
          flash_lvl_d = 1'b1;
          pers_d      = 16'd0;
        end else if (conflict_s) begin
          // A conflicting request never reaches the lamps, even before it latches.
          lamp_d = LAMPS_RED;
        end else begin
          lamp_d = lamp_in_s;
        end
      end
      ST_FLASH: begin
        if (fault_clr) begin
          state_d    = ST_INIT;
          init_cnt_d = 16'd0;
          fault_d    = 1'b0;
          code_d     = FC_NONE;
        end else begin
          if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d = 16'd0;
            flash_lvl_d = ~flash_lvl_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 16'd1;
            flash_lvl_d = flash_lvl_q;
          end
          lamp_d = flash_lvl_d ? LAMPS_RED : 6'd0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = 16'd0;
        fault_d    = 1'b0;
        code_d     = FC_NONE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= 16'd0;
      flash_cnt_q <= 16'd0;
      flash_lvl_q <= 1'b1;
      pers_q      <= 16'd0;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      lamp_q      <= LAMPS_RED;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_lvl_q <= flash_lvl_d;
      pers_q      <= pers_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      lamp_q      <= lamp_d;
    end
  end

  assign {EW_Red_o, EW_Green_o, EW_Yellow_o, NS_Red_o, NS_Green_o, NS_Yellow_o} = lamp_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Directed bench for tlc_lamp_monitor: default instance plus a PERSIST=1 instance,
// both checked every cycle against a sample-history model.
module tb_tlc_lamp_monitor;

  localparam int STARTUP    = 4;
  localparam int YEL_MIN    = 2;
  localparam int FLASH_HALF = 5;
  localparam int HMAX       = 256;

  // {EW_R, EW_G, EW_Y, NS_R, NS_G, NS_Y}
  localparam logic [5:0] RR = 6'b100_100;
  localparam logic [5:0] GR = 6'b010_100;
  localparam logic [5:0] YR = 6'b001_100;
  localparam logic [5:0] RG = 6'b100_010;
  localparam logic [5:0] RY = 6'b100_001;
  localparam logic [5:0] GG = 6'b010_010;
  localparam logic [5:0] XR = 6'b110_100;
  localparam logic [5:0] XG = 6'b110_010;

  logic       clk = 1'b0;
  logic       reset;
  logic       fault_clr;
  logic [5:0] lin;
  wire  [5:0] out0, out1;
  wire        f0, f1;
  wire  [2:0] c0, c1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 = all-red start-up, 1 = pass, 2 = flashing.
  int         mode[2];
  int         tcnt[2];
  int         fcnt[2];
  int         hlen[2];
  bit         mfault[2];
  int         mcode[2];
  logic [5:0] mout[2];
  logic [5:0] hl[2][HMAX];
  bit         hp[2][HMAX];

  always #5 clk = ~clk;

  tlc_lamp_monitor #(.STARTUP(STARTUP), .PERSIST(2), .YEL_MIN(YEL_MIN), .FLASH_HALF(FLASH_HALF)) u_dut0 (
    .clk(clk), .reset(reset),
    .EW_Red(lin[5]), .EW_Green(lin[4]), .EW_Yellow(lin[3]),
    .NS_Red(lin[2]), .NS_Green(lin[1]), .NS_Yellow(lin[0]),
    .fault_clr(fault_clr),
    .EW_Red_o(out0[5]), .EW_Green_o(out0[4]), .EW_Yellow_o(out0[3]),
    .NS_Red_o(out0[2]), .NS_Green_o(out0[1]), .NS_Yellow_o(out0[0]),
    .fault(f0), .fault_code(c0)
  );

  tlc_lamp_monitor #(.STARTUP(STARTUP), .PERSIST(1), .YEL_MIN(YEL_MIN), .FLASH_HALF(FLASH_HALF)) u_dut1 (
    .clk(clk), .reset(reset),
    .EW_Red(lin[5]), .EW_Green(lin[4]), .EW_Yellow(lin[3]),
    .NS_Red(lin[2]), .NS_Green(lin[1]), .NS_Yellow(lin[0]),
    .fault_clr(fault_clr),
    .EW_Red_o(out1[5]), .EW_Green_o(out1[4]), .EW_Yellow_o(out1[3]),
    .NS_Red_o(out1[2]), .NS_Green_o(out1[1]), .NS_Yellow_o(out1[0]),
    .fault(f1), .fault_code(c1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int persist_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // 1 = red, 2 = yellow, 3 = green when exactly one lamp is lit, else 0.
  function automatic int kind(input logic [5:0] l, input int d);
    logic [2:0] v;
    v = (d == 0) ? l[5:3] : l[2:0];
    case (v)
      3'b100:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit conflict(input logic [5:0] l);
    return (l[4] | l[3]) && (l[1] | l[0]);
  endfunction

  function automatic bit offending(input logic [5:0] l);
    return conflict(l) || (kind(l, 0) == 0) || (kind(l, 1) == 0);
  endfunction

  // Fault code earned by the newest pass sample, judged from the whole history.
  function automatic int pass_code(input int k);
    int         n;
    int         streak;
    int         run;
    bit         skip;
    bit         shrt;
    bit         red;
    logic [5:0] cur;
    n      = hlen[k];
    cur    = hl[k][n-1];
    streak = 0;
    skip   = 1'b0;
    shrt   = 1'b0;
    for (int j = n - 1; j >= 0; j--) begin
      if (!(hp[k][j] && offending(hl[k][j]))) break;
      streak++;
    end
    for (int d = 0; d < 2; d++) begin
      red = (d == 0) ? cur[5] : cur[2];
      if (red && n >= 2 && kind(hl[k][n-2], d) == 3) skip = 1'b1;
      run = 0;
      for (int j = n - 2; j >= 0; j--) begin
        if (kind(hl[k][j], d) != 2) break;
        run++;
      end
      if (red && run >= 1 && ((run > 255) ? 255 : run) < YEL_MIN) shrt = 1'b1;
    end
    if (streak >= persist_of(k) && conflict(cur)) return 1;
    if (streak >= persist_of(k)) return 2;
    if (skip) return 3;
    if (shrt) return 4;
    return 0;
  endfunction

  task automatic push(input int k, input logic [5:0] l, input bit p);
    if (hlen[k] < HMAX) begin
      hl[k][hlen[k]] = l;
      hp[k][hlen[k]] = p;
      hlen[k]++;
    end
  endtask

  task automatic m_restart(input int k);
    mode[k]   = 0;
    tcnt[k]   = 0;
    hlen[k]   = 0;
    mfault[k] = 1'b0;
    mcode[k]  = 0;
    mout[k]   = RR;
  endtask

  task automatic m_step(input int k, input logic [5:0] l, input logic clr, input logic rst);
    int c;
    if (rst) begin
      m_restart(k);
    end else if (mode[k] == 0) begin
      push(k, l, 1'b0);
      mout[k] = RR;
      tcnt[k]++;
      if (tcnt[k] == STARTUP) mode[k] = 1;
    end else if (mode[k] == 1) begin
      push(k, l, 1'b1);
      c = pass_code(k);
      if (c != 0) begin
        mfault[k] = 1'b1;
        mcode[k]  = c;
        mode[k]   = 2;
        fcnt[k]   = 0;
        mout[k]   = RR;
      end else begin
        mout[k] = conflict(l) ? RR : l;
      end
    end else if (clr) begin
      m_restart(k);
    end else begin
      fcnt[k]++;
      mout[k] = (((fcnt[k] / FLASH_HALF) % 2) == 0) ? RR : 6'd0;
    end
  endtask

  task automatic cyc(input logic [5:0] l, input logic clr, input logic rst);
    lin       = l;
    fault_clr = clr;
    reset     = rst;
    @(posedge clk);
    m_step(0, l, clr, rst);
    m_step(1, l, clr, rst);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lamps0", 32'(out0), 32'(mout[0]));
      chk("fault0", 32'(f0), 32'(mfault[0]));
      chk("code0", 32'(c0), 32'(mcode[0]));
      chk("lamps1", 32'(out1), 32'(mout[1]));
      chk("fault1", 32'(f1), 32'(mfault[1]));
      chk("code1", 32'(c1), 32'(mcode[1]));
    end
  end

  initial begin
    lin = RR; fault_clr = 1'b0; reset = 1'b1;
    cyc(RR, 1'b0, 1'b1);
    chk_en = 1'b1;
    cyc(RR, 1'b0, 1'b1);
    chk("rst_fault", 32'(f0), 32'd0);
    chk("rst_code", 32'(c0), 32'd0);
    chk("rst_lamps", 32'(out0), 32'(RR));

    // Normal cycle: start-up reds, then one-cycle-late mirroring.
    repeat (3) cyc(GR, 1'b0, 1'b0);
    cyc(YR, 1'b0, 1'b0);
    chk("init_red", 32'(out0), 32'(RR));
    cyc(YR, 1'b0, 1'b0);
    chk("mirror_yr", 32'(out0), 32'(YR));
    repeat (3) cyc(RG, 1'b0, 1'b0);
    chk("mirror_rg", 32'(out0), 32'(RG));
    chk("normal_nofault", 32'(f0), 32'd0);
    repeat (2) cyc(RY, 1'b0, 1'b0);
    cyc(RR, 1'b0, 1'b0);
    cyc(GR, 1'b0, 1'b0);

    // Conflict: one sample is masked, two latch; then red flashing.
    cyc(GG, 1'b0, 1'b0);
    chk("glitch_masked", 32'(out0), 32'(RR));
    chk("glitch_nofault", 32'(f0), 32'd0);
    chk("p1_conflict", 32'(c1), 32'd1);
    cyc(GG, 1'b0, 1'b0);
    chk("conflict_fault", 32'(f0), 32'd1);
    chk("conflict_code", 32'(c0), 32'd1);
    chk("conflict_lamps", 32'(out0), 32'(RR));
    for (int i = 1; i <= 10; i++) begin
      cyc(RR, 1'b0, 1'b0);
      if (i == 5) chk("flash_low", 32'(out0), 32'd0);
      if (i == 10) chk("flash_high", 32'(out0), 32'(RR));
    end

    // Clear from FLASH, start-up again, then clear in PASS is ignored.
    cyc(RR, 1'b1, 1'b0);
    chk("clr_fault", 32'(f0), 32'd0);
    chk("clr_code", 32'(c0), 32'd0);
    repeat (4) cyc(RG, 1'b0, 1'b0);
    chk("clr_init_red", 32'(out0), 32'(RR));
    cyc(RG, 1'b0, 1'b0);
    chk("clr_pass", 32'(out0), 32'(RG));
    cyc(RG, 1'b1, 1'b0);
    chk("clr_in_pass_fault", 32'(f0), 32'd0);
    chk("clr_in_pass_lamps", 32'(out0), 32'(RG));

    // Skipped yellow.
    repeat (2) cyc(RY, 1'b0, 1'b0);
    cyc(RR, 1'b0, 1'b0);
    cyc(GR, 1'b0, 1'b0);
    cyc(RR, 1'b0, 1'b0);
    chk("skip_code", 32'(c0), 32'd3);

    // Short yellow.
    cyc(RR, 1'b1, 1'b0);
    repeat (4) cyc(RR, 1'b0, 1'b0);
    cyc(GR, 1'b0, 1'b0);
    cyc(YR, 1'b0, 1'b0);
    cyc(RR, 1'b0, 1'b0);
    chk("short_code", 32'(c0), 32'd4);

    // Reset mid-FLASH wins over a simultaneous clear.
    cyc(RR, 1'b1, 1'b1);
    chk("rst_flash_fault", 32'(f0), 32'd0);
    chk("rst_flash_code", 32'(c0), 32'd0);
    repeat (4) cyc(RR, 1'b0, 1'b0);
    cyc(RR, 1'b0, 1'b0);

    // Not one-hot: single sample tolerated, two latch.
    cyc(XR, 1'b0, 1'b0);
    chk("onehot_glitch_nofault", 32'(f0), 32'd0);
    chk("p1_onehot", 32'(c1), 32'd2);
    cyc(RR, 1'b0, 1'b0);
    chk("onehot_recover", 32'(f0), 32'd0);
    repeat (2) cyc(XR, 1'b0, 1'b0);
    chk("onehot_code", 32'(c0), 32'd2);

    // Conflict and skipped yellow together: priority depends on persistence.
    cyc(RR, 1'b0, 1'b1);
    repeat (4) cyc(RR, 1'b0, 1'b0);
    cyc(GR, 1'b0, 1'b0);
    cyc(XG, 1'b0, 1'b0);
    chk("prio_p1_code", 32'(c1), 32'd1);
    chk("prio_p2_code", 32'(c0), 32'd3);
    repeat (2) cyc(RR, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlc_lamp_monitor.md
TLC_LAMP_MONITOR -- requirements
Module: tlc_lamp_monitor

Interface
REQ-001 The block SHALL have parameter STARTUP, default 4: cycles in all-red INIT before lamps follow the controller.
REQ-002 The block SHALL have parameter PERSIST, default 2: consecutive cycles a static fault must hold before it latches.
REQ-003 The block SHALL have parameter YEL_MIN, default 2: minimum consecutive yellow cycles before red.
REQ-004 The block SHALL have parameter FLASH_HALF, default 5: half-period of fail-safe red flashing, in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports EW_Red, EW_Green, EW_Yellow, NS_Red, NS_Green, NS_Yellow, each input, 1 bit: lamp requests from the traffic light controller.
REQ-008 The block SHALL have port fault_clr, input, 1 bit: single-cycle operator clear request.
REQ-009 The block SHALL have ports EW_Red_o, EW_Green_o, EW_Yellow_o, NS_Red_o, NS_Green_o, NS_Yellow_o, each output, 1 bit: registered lamp drives.
REQ-010 The block SHALL have port fault, output, 1 bit: latched fault flag.
REQ-011 The block SHALL have port fault_code, output, 3 bits: cause of the latched fault.

Function
REQ-012 The block SHALL implement the states INIT, PASS and FLASH.
REQ-013 In INIT, only EW_Red_o and NS_Red_o SHALL be driven high; INIT SHALL move to PASS after exactly STARTUP cycles.
REQ-014 In PASS, each lamp output SHALL equal its input from the previous cycle (1-cycle latency).
REQ-015 Checks SHALL run only in PASS; direction history and the yellow counter SHALL be cleared on INIT entry.
REQ-016 A conflict (code 1) SHALL be any cycle where both directions have Green or Yellow high.
REQ-017 A not-one-hot fault (code 2) SHALL be any cycle where a direction has zero, or more than one, lamp high.
REQ-018 Codes 1 and 2 SHALL latch only after PERSIST consecutive offending samples; a single-cycle glitch with PERSIST=2 SHALL NOT latch.
REQ-019 Skipped yellow (code 3) SHALL be a direction going Green at sample n to Red at sample n+1, and SHALL latch immediately.
REQ-020 Short yellow (code 4) SHALL be a Yellow run shorter than YEL_MIN cycles ending in Red, and SHALL latch immediately.
REQ-021 The yellow run counter SHALL be 8 bits and SHALL saturate at 255.
REQ-022 When several causes qualify in the same cycle, the latched code SHALL follow the priority 1 > 2 > 3 > 4.
REQ-023 On the latching edge, fault SHALL go to 1, fault_code SHALL be set, and the state SHALL become FLASH.
REQ-024 fault_code SHALL then hold until fault_clr or reset.
REQ-025 In FLASH, all Green and Yellow outputs SHALL be 0; EW_Red_o and NS_Red_o SHALL be equal and SHALL toggle every FLASH_HALF cycles, starting high.
REQ-026 fault_clr SHALL be honoured only in FLASH; it SHALL clear fault and fault_code and enter INIT.
REQ-027 fault_clr in INIT or PASS SHALL be ignored.
REQ-028 No combination of inputs SHALL ever drive both directions non-red at the outputs.

Reset
REQ-029 When reset is high at a rising clk edge, the block SHALL enter INIT with the STARTUP counter at 0, fault=0, fault_code=0, EW_Red_o=NS_Red_o=1, and all other outputs 0.
REQ-030 Reset SHALL take effect from any state, including mid-FLASH and mid-yellow, and SHALL take priority over fault_clr.

Structure
REQ-031 A shared package tlc_pkg SHALL hold the state encoding and the fault code constants FC_NONE=0, FC_CONFLICT=1, FC_ONEHOT=2, FC_SKIPYEL=3 and FC_SHORTYEL=4.
REQ-032 A sub-module tlc_dir_checker SHALL be instantiated once per direction and SHALL provide the one-hot flag, previous-lamp history, yellow counter, and the skipped-yellow and short-yellow strobes.
REQ-033 The top level SHALL hold the FSM, the persistence counter, the flash counter and the priority encoder.

Verification
REQ-034 The bench SHALL cover: reset 2 cycles, then EW_Green/NS_Red 3 cycles, EW_Yellow/NS_Red 2 cycles, EW_Red/NS_Green -> reds only for 4 cycles, then outputs mirror inputs 1 cycle late with fault=0.
REQ-035 The bench SHALL cover: EW_Green and NS_Green held 2 cycles in PASS -> fault=1 and code=1 on the 2nd edge, greens 0, reds high 5 cycles then low 5 cycles, repeating.
REQ-036 The bench SHALL cover: EW_Green followed directly by EW_Red -> code=3 on that edge; EW_Yellow for 1 cycle then Red -> code=4.
REQ-037 The bench SHALL cover: EW_Red and EW_Green both high for 1 cycle -> no fault; the same held 2 cycles -> code=2.
REQ-038 The bench SHALL cover: conflict and skipped yellow in the same cycle with PERSIST=1 -> code=1.
REQ-039 The bench SHALL cover: fault_clr pulse in FLASH -> fault=0 and code=0, 4 all-red cycles, then PASS; fault_clr in PASS -> no effect; reset mid-FLASH -> INIT.
